stage_insn_buffer: RTL

Parametrised instruction-bundle buffer that decouples two Tachyon pipeline stages, primarily fetch and decode. It carries the stage bundle (valid, word-aligned address, instruction word) through a DEPTH-entry FIFO with a valid/ready handshake on both sides. It also provides a single-cycle pipeline flush, an occupancy count and an almost-full indication. It replaces a bare bundle register wherever back-pressure must be absorbed without a combinational ready path.

---
 rtl/stage_insn_buffer.sv | 70 +++++++
 1 files changed

// File: rtl/stage_insn_buffer.sv
// stage_insn_buffer: DEPTH-entry bundle FIFO between two pipeline stages.
// Outputs depend only on registered state and flush, never on the opposite handshake.
`ifndef PHYS_ADDR_WIDTH
`define PHYS_ADDR_WIDTH 32
`endif
module stage_insn_buffer #(
    parameter int ADDR_WIDTH  = `PHYS_ADDR_WIDTH,
    parameter int INSN_SIZE   = 4,
    parameter int INSN_WIDTH  = INSN_SIZE * 8,
    parameter int ADDR_START  = $clog2(INSN_SIZE),
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1,
    parameter int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             in_valid,
    input  logic [ADDR_WIDTH-ADDR_START-1:0] in_addr,
    input  logic [INSN_WIDTH-1:0]            in_insn,
    output logic                             in_ready,
    output logic                             out_valid,
    output logic [ADDR_WIDTH-ADDR_START-1:0] out_addr,
    output logic [INSN_WIDTH-1:0]            out_insn,
    input  logic                             out_ready,
    output logic [CNT_W-1:0]                 count,
    output logic                             almost_full
);
    localparam int PW = $clog2(DEPTH);
    localparam int AW = ADDR_WIDTH - ADDR_START;

    logic [AW-1:0]         addr_mem [DEPTH];
    logic [INSN_WIDTH-1:0] insn_mem [DEPTH];
    logic [PW-1:0]         wp, rp;
    logic                  push, pop;

    assign in_ready    = (count != CNT_W'(DEPTH)) & ~flush;
    assign out_valid   = (count != '0) & ~flush;
    assign push        = in_valid & in_ready;
    assign pop         = out_valid & out_ready;
    assign out_addr    = addr_mem[rp];
    assign out_insn    = insn_mem[rp];
    assign almost_full = count >= CNT_W'(AFULL_LEVEL);

    // Flush only rewinds the pointers; stale storage is unreachable until rewritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wp    <= '0;
            rp    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                insn_mem[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
            wp    <= '0;
            rp    <= '0;
        end else begin
            if (push) begin
                addr_mem[wp] <= in_addr;
                insn_mem[wp] <= in_insn;
                wp           <= wp + PW'(1);
            end
            if (pop)
                rp <= rp + PW'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule
